// File: rtl/spike_accumulator_array_pkg.sv
// Shared types and helpers for the spike accumulator array.
package spike_accumulator_array_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } rd_state_e;

  // Channel-index width; a single channel still needs one bit.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_counter_cell.sv
// One spike counter with optional clamp; exposes this cycle's incremented value for snapshots.
module spike_counter_cell #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic                  i_spike,
  input  logic                  i_close,
  output logic [DATA_WIDTH-1:0] o_count_nxt_c,
  output logic                  o_sat_nxt_c
);

  logic [DATA_WIDTH-1:0] r_count;
  logic                  r_sat;
  logic                  w_full;

  // Value after counting this cycle's spike; a clamped spike only raises sat.
  always_comb begin
    w_full        = &r_count;
    o_count_nxt_c = r_count;
    o_sat_nxt_c   = r_sat;
    if (i_en && i_spike) begin
      if (SATURATE && w_full) begin
        o_sat_nxt_c = 1'b1;
      end else begin
        o_count_nxt_c = r_count + DATA_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_en) begin
      if (i_close) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end else begin
        r_count <= o_count_nxt_c;
        r_sat   <= o_sat_nxt_c;
      end
    end
  end

endmodule

// File: rtl/spike_accumulator_array.sv
// Windowed per-channel spike counters with a snapshot bank streamed out one channel per beat.
module spike_accumulator_array
  import spike_accumulator_array_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WINDOW_LEN   = 256,
  parameter int unsigned SATURATE     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [NUM_CHANNELS-1:0]               spikes,
  input  logic                                  clear,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [chan_width(NUM_CHANNELS)-1:0]   out_channel,
  output logic [DATA_WIDTH-1:0]                 out_count,
  output logic                                  out_sat,
  output logic                                  out_last,
  output logic                                  overrun
);

  localparam int unsigned CW = chan_width(NUM_CHANNELS);
  localparam int unsigned TW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

  logic [TW-1:0]         r_timer;
  logic                  w_close;
  logic [DATA_WIDTH-1:0] w_cnt_nxt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_sat_nxt;
  logic [DATA_WIDTH-1:0] r_snap_cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_snap_sat;
  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic [CW-1:0]         r_idx;
  logic [CW-1:0]         w_idx_nxt;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_stream_nxt;
  logic [DATA_WIDTH-1:0] w_beat_cnt;
  logic                  w_beat_sat;

  assign w_close  = en && (r_timer == TW'(WINDOW_LEN - 1));
  assign w_accept = out_valid && out_ready;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cell
    spike_counter_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE != 0)
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .i_clear       (clear),
      .i_en          (en),
      .i_spike       (spikes[g]),
      .i_close       (w_close),
      .o_count_nxt_c (w_cnt_nxt[g]),
      .o_sat_nxt_c   (w_sat_nxt[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (clear) begin
      r_timer <= '0;
    end else if (en) begin
      r_timer <= w_close ? '0 : r_timer + TW'(1);
    end
  end

  // Readout next-state; a close while streaming is dropped (only overrun records it).
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_close) begin
            w_state_nxt = ST_STREAM;
            w_idx_nxt   = '0;
            w_load      = 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            if (r_idx == CW'(NUM_CHANNELS - 1)) begin
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + CW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
    w_stream_nxt = (w_state_nxt == ST_STREAM);
    w_beat_cnt   = w_load ? w_cnt_nxt[w_idx_nxt] : r_snap_cnt[w_idx_nxt];
    w_beat_sat   = w_load ? w_sat_nxt[w_idx_nxt] : r_snap_sat[w_idx_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_count   <= '0;
      out_sat     <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      out_valid   <= w_stream_nxt;
      out_channel <= w_stream_nxt ? w_idx_nxt : '0;
      out_count   <= w_stream_nxt ? w_beat_cnt : '0;
      out_sat     <= w_stream_nxt && w_beat_sat;
      out_last    <= w_stream_nxt && (w_idx_nxt == CW'(NUM_CHANNELS - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_snap_cnt[i] <= '0;
      end
      r_snap_sat <= '0;
    end else if (w_load) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_snap_cnt[i] <= w_cnt_nxt[i];
      end
      r_snap_sat <= w_sat_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (w_close && (r_state == ST_STREAM)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_accumulator_array.sv
// Three DUT variants share one stimulus stream and are checked each cycle against a window-level model.
module tb_spike_accumulator_array;

  localparam int NCH = 4;
  localparam int NDUT = 3;
  localparam int MAXC = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] spikes;
  logic       clear;
  logic       out_ready;

  logic [NDUT-1:0] o_valid;
  logic [NDUT-1:0] o_sat;
  logic [NDUT-1:0] o_last;
  logic [NDUT-1:0] o_ovr;
  logic [1:0]      o_chan [NDUT];
  logic [3:0]      o_cnt  [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: raw spike totals per window, reduced to the output width only at close.
  int acc      [NDUT][NCH];
  int encyc    [NDUT];
  bit busy     [NDUT];
  int ridx     [NDUT];
  int snap     [NDUT][NCH];
  bit snap_sat [NDUT][NCH];
  bit ovr      [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spike_accumulator_array #(
      .NUM_CHANNELS (4),
      .DATA_WIDTH   (4),
      .WINDOW_LEN   ((g == 0) ? 8 : 20),
      .SATURATE     ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .spikes      (spikes),
      .clear       (clear),
      .out_valid   (o_valid[g]),
      .out_ready   (out_ready),
      .out_channel (o_chan[g]),
      .out_count   (o_cnt[g]),
      .out_sat     (o_sat[g]),
      .out_last    (o_last[g]),
      .overrun     (o_ovr[g])
    );
  end

  function automatic int wl(input int k);
    return (k == 0) ? 8 : 20;
  endfunction

  function automatic bit satf(input int k);
    return k != 2;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s dut%0d: observed %0d expected %0d", tag, k, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      for (int c = 0; c < NCH; c++) acc[k][c] = 0;
      encyc[k] = 0;
      busy[k]  = 1'b0;
      ridx[k]  = 0;
      ovr[k]   = 1'b0;
    end
  endtask

  task automatic model_step();
    bit was_busy;
    if (rst || clear) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NDUT; k++) begin
      was_busy = busy[k];
      if (was_busy && out_ready) begin
        if (ridx[k] == NCH - 1) begin
          busy[k] = 1'b0;
          ridx[k] = 0;
        end else begin
          ridx[k]++;
        end
      end
      if (en) begin
        for (int c = 0; c < NCH; c++) acc[k][c] += int'(spikes[c]);
        encyc[k]++;
        if (encyc[k] == wl(k)) begin
          if (was_busy) begin
            ovr[k] = 1'b1;
          end else begin
            for (int c = 0; c < NCH; c++) begin
              snap[k][c]     = satf(k) ? ((acc[k][c] > MAXC) ? MAXC : acc[k][c]) : (acc[k][c] % (MAXC + 1));
              snap_sat[k][c] = satf(k) && (acc[k][c] > MAXC);
            end
            busy[k] = 1'b1;
            ridx[k] = 0;
          end
          for (int c = 0; c < NCH; c++) acc[k][c] = 0;
          encyc[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      chk("valid", k, 32'(o_valid[k]), 32'(busy[k]));
      chk("channel", k, 32'(o_chan[k]), busy[k] ? 32'(ridx[k]) : 32'd0);
      chk("count", k, 32'(o_cnt[k]), busy[k] ? 32'(snap[k][ridx[k]]) : 32'd0);
      chk("sat", k, 32'(o_sat[k]), busy[k] ? 32'(snap_sat[k][ridx[k]]) : 32'd0);
      chk("last", k, 32'(o_last[k]), 32'(busy[k] && (ridx[k] == NCH - 1)));
      chk("overrun", k, 32'(o_ovr[k]), 32'(ovr[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_rand(input int n, input int ready_pct);
    for (int i = 0; i < n; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      spikes    = 4'($urandom);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      cycle();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spikes = '0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    run(3);
    rst = 1'b0;

    // Basic window on the 8-cycle variant: counts 8,0,8,0.
    en = 1'b1; out_ready = 1'b1; spikes = 4'b0101;
    run(8);
    spikes = 4'b0000;
    for (int b = 0; b < NCH; b++) begin
      chk("basic_valid", 0, 32'(o_valid[0]), 32'd1);
      chk("basic_chan", 0, 32'(o_chan[0]), 32'(b));
      chk("basic_count", 0, 32'(o_cnt[0]), (b % 2 == 0) ? 32'd8 : 32'd0);
      chk("basic_last", 0, 32'(o_last[0]), 32'(b == NCH - 1));
      cycle();
    end
    chk("basic_idle", 0, 32'(o_valid[0]), 32'd0);
    run(4);

    // Saturate vs wrap on the 20-cycle variants.
    do_clear();
    spikes = 4'b0001;
    run(20);
    chk("sat_count", 1, 32'(o_cnt[1]), 32'd15);
    chk("sat_flag", 1, 32'(o_sat[1]), 32'd1);
    chk("wrap_count", 2, 32'(o_cnt[2]), 32'd4);
    chk("wrap_flag", 2, 32'(o_sat[2]), 32'd0);
    spikes = 4'b0000;
    run(6);

    // Backpressure held on beat ch1.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      spikes = 4'($urandom);
      cycle();
    end
    spikes = 4'b0000;
    cycle();
    out_ready = 1'b0;
    run(5);
    chk("bp_chan", 0, 32'(o_chan[0]), 32'd1);
    out_ready = 1'b1;
    run(6);

    // Overrun: readout stalled across a second close, then fresh windows.
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      spikes = 4'($urandom);
      cycle();
    end
    chk("ovr_set", 0, 32'(o_ovr[0]), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      spikes = 4'($urandom);
      cycle();
    end

    // Boundary: spike only on the close cycle, and an en gap stretching the window.
    do_clear();
    spikes = 4'b0000;
    run(7);
    spikes = 4'b1111;
    cycle();
    chk("close_spike", 0, 32'(o_cnt[0]), 32'd1);
    spikes = 4'b0010;
    run(4);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(4);
    chk("gap_count_ch1", 0, 32'(o_cnt[0]), 32'd0);
    cycle();
    chk("gap_count_ch1b", 0, 32'(o_cnt[0]), 32'd8);
    spikes = 4'b0000;
    run(4);

    // Clear mid-stream.
    out_ready = 1'b0;
    spikes = 4'b1010;
    run(10);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clr_valid", 0, 32'(o_valid[0]), 32'd0);
    chk("clr_ovr", 0, 32'(o_ovr[0]), 32'd0);
    out_ready = 1'b1;
    run(12);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    run(10);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    run(12);

    run_rand(400, 70);
    run_rand(200, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
